maze_move_server: RTL and testbench

Shared maze-query engine that produces the `canMoveUp/Right/Down/Left` inputs consumed by every ghost AI block. On each scan request it snapshots each ghost's tile, reads the four neighbouring tiles from the single-port maze ROM and registers per-ghost move-permission bits. Tunnel wrap and ghost-house door rules are applied here, so ghost blocks see only final permissions. It sits between the maze ROM and the ghost AI instances, and is triggered by the 60 Hz move tick.

---
 rtl/maze_pkg.sv | 36 +++
 rtl/maze_neighbor_addr.sv | 74 +++++++
 rtl/maze_move_server.sv | 176 +++++++++++++++++
 tb/tb_maze_move_server.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze move server: default maze geometry, tile
// codes, direction encoding (matches the ghost dir encoding), the scan FSM
// state type and the tile passability helper.
// Optional feature macro used by the design: MAZE_DOOR_EN.
// -----------------------------------------------------------------------------
package maze_pkg;

    localparam int MAZE_W_DEFAULT     = 28;
    localparam int MAZE_H_DEFAULT     = 36;
    localparam int TUNNEL_ROW_DEFAULT = 19;

    localparam logic [1:0] TILE_PATH = 2'b00;
    localparam logic [1:0] TILE_WALL = 2'b01;
    localparam logic [1:0] TILE_DOOR = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_QUERY,
        ST_DRAIN,
        ST_COMMIT
    } maze_state_t;

    // Codes 01 and 11 are both walls; a door only passes when door_ok is set.
    function automatic logic tile_pass(input logic [1:0] code, input logic door_ok);
        return (code == TILE_PATH) || ((code == TILE_DOOR) && door_ok);
    endfunction

endpackage

// File: rtl/maze_neighbor_addr.sv
// -----------------------------------------------------------------------------
// maze_neighbor_addr
// Combinational neighbour-tile address generator. Applies the maze edge rules
// and the tunnel wrap on TUNNEL_ROW.
// Ports:
//   i_x, i_y        latched tile coordinates
//   i_dir           direction (00 up, 01 right, 10 down, 11 left)
//   o_addr          ROM address of the neighbour tile, y*MAZE_W + x
//   o_force_block   neighbour is off-maze (or origin invalid): no read issued
// -----------------------------------------------------------------------------
module maze_neighbor_addr
    import maze_pkg::*;
#(
    parameter int MAZE_W     = MAZE_W_DEFAULT,
    parameter int MAZE_H     = MAZE_H_DEFAULT,
    parameter int TUNNEL_ROW = TUNNEL_ROW_DEFAULT
) (
    input  logic [5:0] i_x,
    input  logic [5:0] i_y,
    input  logic [1:0] i_dir,
    output logic [9:0] o_addr,
    output logic       o_force_block
);

    localparam logic [5:0] X_LIM  = 6'(MAZE_W);
    localparam logic [5:0] Y_LIM  = 6'(MAZE_H);
    localparam logic [5:0] X_LAST = 6'(MAZE_W - 1);
    localparam logic [5:0] Y_LAST = 6'(MAZE_H - 1);
    localparam logic [5:0] Y_TUN  = 6'(TUNNEL_ROW);

    logic [5:0] w_nx;
    logic [5:0] w_ny;
    logic       w_blk;

    always_comb begin
        w_nx  = i_x;
        w_ny  = i_y;
        w_blk = 1'b0;
        if ((i_x >= X_LIM) || (i_y >= Y_LIM)) begin
            w_blk = 1'b1;
        end else begin
            case (i_dir)
                DIR_UP: begin
                    if (i_y == 6'd0) w_blk = 1'b1;
                    else             w_ny  = i_y - 6'd1;
                end
                DIR_RIGHT: begin
                    if (i_x == X_LAST) begin
                        if (i_y == Y_TUN) w_nx  = 6'd0;
                        else              w_blk = 1'b1;
                    end else begin
                        w_nx = i_x + 6'd1;
                    end
                end
                DIR_DOWN: begin
                    if (i_y == Y_LAST) w_blk = 1'b1;
                    else               w_ny  = i_y + 6'd1;
                end
                default: begin
                    if (i_x == 6'd0) begin
                        if (i_y == Y_TUN) w_nx  = X_LAST;
                        else              w_blk = 1'b1;
                    end else begin
                        w_nx = i_x - 6'd1;
                    end
                end
            endcase
        end
    end

    assign o_addr        = ({4'd0, w_ny} * 10'(MAZE_W)) + {4'd0, w_nx};
    assign o_force_block = w_blk;

endmodule

// File: rtl/maze_move_server.sv
// -----------------------------------------------------------------------------
// maze_move_server
// Shared maze-query engine. On scan_req, each ghost in turn has its tile
// latched, its four neighbours read from the single-port maze ROM (U, R, D, L)
// and its move-permission bits committed atomically.
// Optional feature macro: MAZE_DOOR_EN (door tiles pass when door_open[g]=1;
// without it doors are walls and door_open is ignored).
// Ports:
//   clk, reset (async, active-low)
//   scan_req       one-cycle scan start pulse
//   ghostX/ghostY  packed 6-bit tile coordinates, ghost i at [6i+5:6i]
//   door_open      per-ghost door permission
//   rom_rd/rom_addr/rom_data   maze ROM port, data valid cycle after rom_rd
//   canMoveUp/Right/Down/Left  registered permissions, one bit per ghost
//   busy, scan_done            scan status
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | wait for scan_req or a pending request
// ST_LATCH  | snapshot ghost g's X/Y
// ST_QUERY  | four cycles, one neighbour read each (U, R, D, L)
// ST_DRAIN  | capture the last read result
// ST_COMMIT | copy shadow bits to ghost g's outputs, advance or finish
// -----------------------------------------------------------------------------
module maze_move_server
    import maze_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int MAZE_W     = MAZE_W_DEFAULT,
    parameter int MAZE_H     = MAZE_H_DEFAULT,
    parameter int TUNNEL_ROW = TUNNEL_ROW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_req,
    input  logic [6*NUM_GHOSTS-1:0]   ghostX,
    input  logic [6*NUM_GHOSTS-1:0]   ghostY,
    input  logic [NUM_GHOSTS-1:0]     door_open,
    output logic                      rom_rd,
    output logic [9:0]                rom_addr,
    input  logic [1:0]                rom_data,
    output logic [NUM_GHOSTS-1:0]     canMoveUp,
    output logic [NUM_GHOSTS-1:0]     canMoveRight,
    output logic [NUM_GHOSTS-1:0]     canMoveDown,
    output logic [NUM_GHOSTS-1:0]     canMoveLeft,
    output logic                      busy,
    output logic                      scan_done
);

    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    maze_state_t           r_state;
    maze_state_t           w_next;
    logic [GW-1:0]         r_ghost;
    logic [1:0]            r_slot;
    logic [5:0]            r_x;
    logic [5:0]            r_y;
    logic [3:0]            r_shadow;
    logic                  r_pend_vld;
    logic                  r_pend_blk;
    logic [1:0]            r_pend_dir;
    logic                  r_pending;
    logic                  r_busy;
    logic                  r_done;
    logic [NUM_GHOSTS-1:0] r_up;
    logic [NUM_GHOSTS-1:0] r_right;
    logic [NUM_GHOSTS-1:0] r_down;
    logic [NUM_GHOSTS-1:0] r_left;

    logic [9:0]            w_addr;
    logic                  w_force;
    logic                  w_last;
    logic                  w_door_ok;
    logic                  w_query;

    maze_neighbor_addr #(
        .MAZE_W     (MAZE_W),
        .MAZE_H     (MAZE_H),
        .TUNNEL_ROW (TUNNEL_ROW)
    ) u_nbr (
        .i_x           (r_x),
        .i_y           (r_y),
        .i_dir         (r_slot),
        .o_addr        (w_addr),
        .o_force_block (w_force)
    );

`ifdef MAZE_DOOR_EN
    assign w_door_ok = door_open[r_ghost];
`else
    logic w_unused_door;
    assign w_door_ok     = 1'b0;
    assign w_unused_door = ^door_open;
`endif

    assign w_last  = (r_ghost == GW'(NUM_GHOSTS - 1));
    assign w_query = (r_state == ST_QUERY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (scan_req || r_pending) w_next = ST_LATCH;
            ST_LATCH:  w_next = ST_QUERY;
            ST_QUERY:  if (r_slot == 2'd3) w_next = ST_DRAIN;
            ST_DRAIN:  w_next = ST_COMMIT;
            ST_COMMIT: w_next = w_last ? ST_IDLE : ST_LATCH;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Reads are pipelined one slot: the slot issued at one edge is resolved
    // at the next, when rom_data for it is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghost    <= '0;
            r_slot     <= 2'd0;
            r_x        <= 6'd0;
            r_y        <= 6'd0;
            r_shadow   <= 4'd0;
            r_pend_vld <= 1'b0;
            r_pend_blk <= 1'b0;
            r_pend_dir <= 2'd0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_up       <= '0;
            r_right    <= '0;
            r_down     <= '0;
            r_left     <= '0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= (r_state == ST_COMMIT) && w_last;

            // IDLE always consumes a pending request, so clearing there is safe.
            if (r_state == ST_IDLE)  r_pending <= 1'b0;
            else if (scan_req)       r_pending <= 1'b1;

            if (r_state == ST_LATCH) begin
                r_x      <= ghostX[6*r_ghost +: 6];
                r_y      <= ghostY[6*r_ghost +: 6];
                r_shadow <= 4'd0;
            end

            r_slot <= w_query ? (r_slot + 2'd1) : 2'd0;

            r_pend_vld <= w_query;
            r_pend_dir <= r_slot;
            r_pend_blk <= w_force;
            if (r_pend_vld)
                r_shadow[r_pend_dir] <= !r_pend_blk && tile_pass(rom_data, w_door_ok);

            if (r_state == ST_COMMIT) begin
                r_up[r_ghost]    <= r_shadow[DIR_UP];
                r_right[r_ghost] <= r_shadow[DIR_RIGHT];
                r_down[r_ghost]  <= r_shadow[DIR_DOWN];
                r_left[r_ghost]  <= r_shadow[DIR_LEFT];
                r_ghost          <= w_last ? '0 : (r_ghost + GW'(1));
            end
        end
    end

    assign rom_rd       = w_query && !w_force;
    assign rom_addr     = rom_rd ? w_addr : 10'd0;
    assign canMoveUp    = r_up;
    assign canMoveRight = r_right;
    assign canMoveDown  = r_down;
    assign canMoveLeft  = r_left;
    assign busy         = r_busy;
    assign scan_done    = r_done;

endmodule

// File: tb/tb_maze_move_server.sv
module tb_maze_move_server;
    import maze_pkg::*;

    logic        clk;
    logic        reset;
    logic        scan_req;
    logic [23:0] ghostX;
    logic [23:0] ghostY;
    logic [3:0]  door_open;
    logic        rom_rd;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_data;
    logic [3:0]  canMoveUp;
    logic [3:0]  canMoveRight;
    logic [3:0]  canMoveDown;
    logic [3:0]  canMoveLeft;
    logic        busy;
    logic        scan_done;

    logic [1:0]  mem [0:1007];
    int          n_chk;
    int          n_fail;

`ifdef MAZE_DOOR_EN
    localparam logic DOOR_EXP = 1'b1;
`else
    localparam logic DOOR_EXP = 1'b0;
`endif

    maze_move_server dut (
        .clk          (clk),
        .reset        (reset),
        .scan_req     (scan_req),
        .ghostX       (ghostX),
        .ghostY       (ghostY),
        .door_open    (door_open),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .canMoveUp    (canMoveUp),
        .canMoveRight (canMoveRight),
        .canMoveDown  (canMoveDown),
        .canMoveLeft  (canMoveLeft),
        .busy         (busy),
        .scan_done    (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: data appears the cycle after the read strobe.
    initial rom_data = 2'b00;
    always @(posedge clk) if (rom_rd) rom_data <= mem[rom_addr];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_scan();
        scan_req = 1'b1;
        @(posedge clk);
        #1;
        scan_req = 1'b0;
    endtask

    task automatic set_ghost(input int g, input int x, input int y);
        ghostX[6*g +: 6] = 6'(x);
        ghostY[6*g +: 6] = 6'(y);
    endtask

    task automatic fill_path();
        for (int i = 0; i < 1008; i++) mem[i] = TILE_PATH;
    endtask

    task automatic test_reset();
        step(2);
        n_chk++; if (canMoveUp !== 4'h0) begin n_fail++; $display("FAIL rst_up got %h exp 0", canMoveUp); end
        n_chk++; if (canMoveRight !== 4'h0) begin n_fail++; $display("FAIL rst_right got %h exp 0", canMoveRight); end
        n_chk++; if (canMoveDown !== 4'h0) begin n_fail++; $display("FAIL rst_down got %h exp 0", canMoveDown); end
        n_chk++; if (canMoveLeft !== 4'h0) begin n_fail++; $display("FAIL rst_left got %h exp 0", canMoveLeft); end
        n_chk++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd got %b exp 0", rom_rd); end
        n_chk++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr got %0d exp 0", rom_addr); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", scan_done); end
        reset = 1'b1;
        step(2);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_wall_up();
        fill_path();
        mem[433] = TILE_WALL;
        set_ghost(0, 1, 1); set_ghost(1, 1, 2); set_ghost(2, 13, 16); set_ghost(3, 20, 20);
        pulse_scan();
        step(1);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wall_busy1 got %b exp 1", busy); end
        step(19);
        n_chk++; if (canMoveRight[2] !== 1'b0) begin n_fail++; $display("FAIL wall_r2_early got %b exp 0", canMoveRight[2]); end
        step(1);
        n_chk++; if ({canMoveUp[2], canMoveRight[2], canMoveDown[2], canMoveLeft[2]} !== 4'b0111)
            begin n_fail++; $display("FAIL wall_urdl2 got %b exp 0111", {canMoveUp[2], canMoveRight[2], canMoveDown[2], canMoveLeft[2]}); end
        n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL wall_done21 got %b exp 0", scan_done); end
        step(6);
        n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL wall_done27 got %b exp 0", scan_done); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wall_busy27 got %b exp 1", busy); end
        step(1);
        n_chk++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL wall_done28 got %b exp 1", scan_done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wall_busy28 got %b exp 0", busy); end
        step(1);
        n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL wall_done29 got %b exp 0", scan_done); end
    endtask

    task automatic test_edges();
        fill_path();
        set_ghost(0, 0, 19); set_ghost(1, 5, 0); set_ghost(2, 5, 35); set_ghost(3, 28, 3);
        pulse_scan();
        step(1);
        n_chk++; if ({rom_rd, rom_addr} !== {1'b1, 10'd504}) begin n_fail++; $display("FAIL tun_u_addr got %b/%0d exp 1/504", rom_rd, rom_addr); end
        step(1);
        n_chk++; if (rom_addr !== 10'd533) begin n_fail++; $display("FAIL tun_r_addr got %0d exp 533", rom_addr); end
        step(1);
        n_chk++; if (rom_addr !== 10'd560) begin n_fail++; $display("FAIL tun_d_addr got %0d exp 560", rom_addr); end
        step(1);
        n_chk++; if ({rom_rd, rom_addr} !== {1'b1, 10'd559}) begin n_fail++; $display("FAIL tun_l_addr got %b/%0d exp 1/559", rom_rd, rom_addr); end
        step(3);
        n_chk++; if ({canMoveUp[0], canMoveRight[0], canMoveDown[0], canMoveLeft[0]} !== 4'b1111)
            begin n_fail++; $display("FAIL tun_urdl0 got %b exp 1111", {canMoveUp[0], canMoveRight[0], canMoveDown[0], canMoveLeft[0]}); end
        step(7);
        n_chk++; if ({canMoveUp[1], canMoveLeft[1]} !== 2'b01) begin n_fail++; $display("FAIL top_ul1 got %b exp 01", {canMoveUp[1], canMoveLeft[1]}); end
        step(7);
        n_chk++; if ({canMoveUp[2], canMoveDown[2]} !== 2'b10) begin n_fail++; $display("FAIL bot_ud2 got %b exp 10", {canMoveUp[2], canMoveDown[2]}); end
        step(1);
        n_chk++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL inval_rd got %b exp 0", rom_rd); end
        step(6);
        n_chk++; if ({canMoveUp[3], canMoveRight[3], canMoveDown[3], canMoveLeft[3]} !== 4'b0000)
            begin n_fail++; $display("FAIL inval_urdl3 got %b exp 0000", {canMoveUp[3], canMoveRight[3], canMoveDown[3], canMoveLeft[3]}); end
        n_chk++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL edge_done got %b exp 1", scan_done); end

        set_ghost(0, 0, 5); set_ghost(1, 27, 19); set_ghost(2, 27, 5); set_ghost(3, 27, 34);
        mem[1007] = TILE_WALL;
        pulse_scan();
        step(4);
        n_chk++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL noTun_l_rd got %b exp 0", rom_rd); end
        step(3);
        n_chk++; if ({canMoveUp[0], canMoveLeft[0]} !== 2'b10) begin n_fail++; $display("FAIL noTun_ul0 got %b exp 10", {canMoveUp[0], canMoveLeft[0]}); end
        step(2);
        n_chk++; if ({rom_rd, rom_addr} !== {1'b1, 10'd532}) begin n_fail++; $display("FAIL tun_r_wrap got %b/%0d exp 1/532", rom_rd, rom_addr); end
        step(5);
        n_chk++; if ({canMoveRight[1], canMoveLeft[1]} !== 2'b11) begin n_fail++; $display("FAIL tun_rl1 got %b exp 11", {canMoveRight[1], canMoveLeft[1]}); end
        step(7);
        n_chk++; if ({canMoveRight[2], canMoveLeft[2]} !== 2'b01) begin n_fail++; $display("FAIL noTun_rl2 got %b exp 01", {canMoveRight[2], canMoveLeft[2]}); end
        step(3);
        n_chk++; if ({rom_rd, rom_addr} !== {1'b1, 10'd1007}) begin n_fail++; $display("FAIL max_addr got %b/%0d exp 1/1007", rom_rd, rom_addr); end
        step(4);
        n_chk++; if ({canMoveUp[3], canMoveDown[3]} !== 2'b10) begin n_fail++; $display("FAIL max_ud3 got %b exp 10", {canMoveUp[3], canMoveDown[3]}); end
        n_chk++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL edge_done2 got %b exp 1", scan_done); end
    endtask

    task automatic test_door();
        fill_path();
        mem[433] = TILE_DOOR;
        for (int g = 0; g < 4; g++) set_ghost(g, 13, 16);
        door_open = 4'b0010;
        pulse_scan();
        step(7);
        n_chk++; if (canMoveUp[0] !== 1'b0) begin n_fail++; $display("FAIL door_u0 got %b exp 0", canMoveUp[0]); end
        step(7);
        n_chk++; if (canMoveUp[1] !== DOOR_EXP) begin n_fail++; $display("FAIL door_u1 got %b exp %b", canMoveUp[1], DOOR_EXP); end
        n_chk++; if (canMoveRight[1] !== 1'b1) begin n_fail++; $display("FAIL door_r1 got %b exp 1", canMoveRight[1]); end
        step(7);
        n_chk++; if (canMoveUp[2] !== 1'b0) begin n_fail++; $display("FAIL door_u2 got %b exp 0", canMoveUp[2]); end
        step(7);
        n_chk++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL door_done got %b exp 1", scan_done); end
    endtask

    task automatic test_back_to_back();
        int t;
        int t1;
        int extra;
        bit found;
        pulse_scan();
        step(4);
        pulse_scan();
        step(4);
        pulse_scan();
        t = 10; found = 1'b0;
        while (!found && t < 60) begin step(1); t++; if (scan_done) found = 1'b1; end
        n_chk++; if (t !== 28) begin n_fail++; $display("FAIL b2b_first_done got cycle %0d exp 28", t); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy got %b exp 0", busy); end
        step(1);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got %b exp 1", busy); end
        t1 = 1; found = 1'b0;
        while (!found && t1 < 60) begin step(1); t1++; if (scan_done) found = 1'b1; end
        n_chk++; if (t1 !== 29) begin n_fail++; $display("FAIL b2b_gap got %0d exp 29", t1); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin step(1); if (scan_done || busy) extra++; end
        n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_third_scan got %0d active cycles exp 0", extra); end
    endtask

    task automatic test_reset_mid();
        fill_path();
        mem[433] = TILE_WALL;
        set_ghost(0, 1, 1); set_ghost(1, 1, 2); set_ghost(2, 13, 16); set_ghost(3, 20, 20);
        pulse_scan();
        step(9);
        n_chk++; if (canMoveRight !== 4'hF) begin n_fail++; $display("FAIL mid_pre_right got %h exp f", canMoveRight); end
        reset = 1'b0;
        #1;
        n_chk++; if ({canMoveUp, canMoveRight, canMoveDown, canMoveLeft} !== 16'h0)
            begin n_fail++; $display("FAIL mid_clear got %h exp 0", {canMoveUp, canMoveRight, canMoveDown, canMoveLeft}); end
        n_chk++; if ({busy, scan_done, rom_rd} !== 3'b000) begin n_fail++; $display("FAIL mid_status got %b exp 000", {busy, scan_done, rom_rd}); end
        #2;
        reset = 1'b1;
        step(1);
        pulse_scan();
        step(27);
        n_chk++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL post_done27 got %b exp 0", scan_done); end
        step(1);
        n_chk++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL post_done28 got %b exp 1", scan_done); end
        n_chk++; if (canMoveUp !== 4'b1011) begin n_fail++; $display("FAIL post_up got %b exp 1011", canMoveUp); end
        n_chk++; if (canMoveRight[2] !== 1'b1) begin n_fail++; $display("FAIL post_r2 got %b exp 1", canMoveRight[2]); end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        scan_req  = 1'b0;
        ghostX    = '0;
        ghostY    = '0;
        door_open = 4'h0;
        fill_path();
        test_reset();
        test_wall_up();
        test_edges();
        test_door();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
